// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with multiply-accumulate modes.
// An op is latched on start, runs a fixed number of busy cycles, then writes HI/LO.
module mult_div_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hlwrite,
  input  logic             hlsel,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  hi_q, lo_q;

  logic              launch;
  logic              last;
  logic              start_is_div;
  logic              op_is_div;

  assign launch       = (state_q == StIdle) && start && !cancel;
  assign last         = (state_q == StRun) && (cnt_q == '0);
  assign start_is_div = (mdop[2:1] == 2'b01);
  assign op_is_div    = (op_q[2:1] == 2'b01);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (launch) state_d = StRun;
      StRun:  if (cancel || (cnt_q == '0)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == StRun);
  end

  // Counter holds remaining busy cycles minus one; operands are latched at launch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (launch) begin
      cnt_q <= start_is_div ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);
      op_q  <= mdop;
      a_q   <= a;
      b_q   <= b;
    end else if (state_q == StRun) begin
      if (cancel) begin
        cnt_q <= '0;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // Datapath: bit 0 of the opcode selects unsigned operation for every op class
  logic                 a_neg, b_neg;
  logic [2*WIDTH-1:0]   a_ext, b_ext, prod, acc, result;
  logic [WIDTH-1:0]     a_mag, b_mag, q_mag, r_mag, quot, rem;
  logic                 wb_en;

  always_comb begin
    a_neg = !op_q[0] && a_q[WIDTH-1];
    b_neg = !op_q[0] && b_q[WIDTH-1];
    a_ext = {{WIDTH{a_neg}}, a_q};
    b_ext = {{WIDTH{b_neg}}, b_q};
    prod  = a_ext * b_ext;
    acc   = {hi_q, lo_q};
  end

  // Signed divide via magnitudes; MIN/-1 falls out as quotient MIN, remainder 0
  always_comb begin
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end else begin
      q_mag = '0;
      r_mag = '0;
    end
    quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem  = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    result = prod;
    case (op_q)
      3'b000, 3'b001: result = prod;
      3'b010, 3'b011: result = {rem, quot};
      3'b100, 3'b101: result = acc + prod;
      3'b110, 3'b111: result = acc - prod;
      default:        result = prod;
    endcase
    wb_en = !(op_is_div && (b_q == '0));
  end

  // HI/LO: write-back on the falling busy edge unless cancelled; mthi/mtlo only when idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (last) begin
      if (!cancel && wb_en) begin
        hi_q <= result[2*WIDTH-1:WIDTH];
        lo_q <= result[WIDTH-1:0];
      end
    end else if ((state_q == StIdle) && hlwrite && !start && !cancel) begin
      if (hlsel) begin
        lo_q <= wdata;
      end else begin
        hi_q <= wdata;
      end
    end
  end

  assign rdata = hlsel ? lo_q : hi_q;

endmodule
